i2c_slave_nibble_rx: RTL and testbench

Write-only I2C slave receiver that sits directly upstream of the RAM write controller. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit slave address, ACKs each accepted byte, and hands every received data byte downstream as two 4-bit nibbles, high nibble first, each qualified by a one-cycle `E` strobe. The downstream controller assembles the nibbles into bytes and writes them to the 32x8 RAM.

---
 rtl/i2c_slave_nibble_rx_if.sv | 12 +
 rtl/i2c_slave_nibble_rx.sv | 198 +++++++++++++++++++
 tb/tb_i2c_slave_nibble_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_nibble_rx_if.sv
// Pad-side I2C lines plus the nibble strobe handed to the RAM write controller.
interface i2c_slave_nibble_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [3:0] data;
  logic       E;
  logic       busy;

  modport slave  (input scl_in, sda_in, output sda_oe, data, E, busy);
  modport master (output scl_in, sda_in, input sda_oe, data, E, busy);
endinterface

// File: rtl/i2c_slave_nibble_rx.sv
// Write-only I2C slave: address match, ACK, and each data byte forwarded as two E-qualified nibbles.
// Optional I2C_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizers.
module i2c_slave_nibble_rx #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned MAX_BYTES  = 32
) (
  input logic                   clk,
  input logic                   reset,
  i2c_slave_nibble_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  localparam logic [5:0] MAX_B = 6'(MAX_BYTES);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_d, sda_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_win, sda_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_win <= '1;
      sda_win <= '1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      scl_win <= {scl_win[1:0], scl_sync[1]};
      sda_win <= {sda_win[1:0], sda_sync[1]};
      scl_f   <= (scl_win[0] & scl_win[1]) | (scl_win[0] & scl_win[2]) | (scl_win[1] & scl_win[2]);
      sda_f   <= (sda_win[0] & sda_win[1]) | (sda_win[0] & sda_win[2]) | (sda_win[1] & sda_win[2]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, byte_w;
  logic [5:0] nbytes, nbytes_n;
  logic       busy_q, busy_n, oe_q, oe_n, e_q, e_n, emit;
  logic [3:0] data_q, data_n, lo_q, lo_n;
  logic [1:0] ph, ph_n;

  assign byte_w = {sr[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sr     <= '0;
      nbytes <= '0;
      busy_q <= 1'b0;
      oe_q   <= 1'b0;
      e_q    <= 1'b0;
      data_q <= '0;
      lo_q   <= '0;
      ph     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sr     <= sr_n;
      nbytes <= nbytes_n;
      busy_q <= busy_n;
      oe_q   <= oe_n;
      e_q    <= e_n;
      data_q <= data_n;
      lo_q   <= lo_n;
      ph     <= ph_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sr_n     = sr;
    nbytes_n = nbytes;
    busy_n   = busy_q;
    oe_n     = oe_q;
    emit     = 1'b0;

    if (start_c) begin
      state_n = S_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (stop_c) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            sr_n  = byte_w;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == S_ADDR) begin
                if (byte_w[7:1] == SLAVE_ADDR && !byte_w[0]) begin
                  state_n = S_ADDR_ACK;
                end else begin
                  state_n = S_IGNORE;
                  busy_n  = 1'b0;
                end
              end else if (nbytes < MAX_B) begin
                state_n  = S_DATA_ACK;
                emit     = 1'b1;
                nbytes_n = nbytes + 6'd1;
              end else begin
                state_n = S_IGNORE;
                busy_n  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (state == S_ADDR_ACK) begin
            busy_n   = 1'b1;
            nbytes_n = '0;
          end
          // First SCL fall after bit 8 pulls SDA; the next fall (end of bit 9) releases it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_n = 1'b1;
            end else begin
              oe_n    = 1'b0;
              state_n = S_DATA;
              cnt_n   = '0;
            end
          end
        end
        S_IGNORE: begin
          oe_n   = 1'b0;
          busy_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Nibble sequencer runs independently of the FSM so a START/STOP cannot cut off the low nibble.
  always_comb begin
    e_n    = 1'b0;
    data_n = data_q;
    lo_n   = lo_q;
    ph_n   = ph;
    if (ph == 2'd2) begin
      ph_n = 2'd1;
    end else if (ph == 2'd1) begin
      e_n    = 1'b1;
      data_n = lo_q;
      ph_n   = 2'd0;
    end
    if (emit) begin
      e_n    = 1'b1;
      data_n = byte_w[7:4];
      lo_n   = byte_w[3:0];
      ph_n   = 2'd2;
    end
  end

  assign bus.sda_oe = oe_q;
  assign bus.data   = data_q;
  assign bus.E      = e_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_i2c_slave_nibble_rx.sv
// Scoreboard bench: the bus master pushes expected nibbles, a monitor pops them on each E strobe.
module tb_i2c_slave_nibble_rx;

  localparam int H = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] d;
    logic       lo;
  } exp_t;
  exp_t q[$];

  i2c_slave_nibble_rx_if ifc ();

  assign ifc.scl_in = scl_m;
  assign ifc.sda_in = sda_m & ~ifc.sda_oe;

  i2c_slave_nibble_rx #(.SLAVE_ADDR(7'h42), .MAX_BYTES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every E strobe must match the head of the queue; low nibbles follow a one-cycle gap.
  logic e_h1 = 1'b0, e_h2 = 1'b0;
  always @(negedge clk) begin
    if (!reset && ifc.E) begin
      if (q.size() == 0) begin
        chk("unexpected_E", {4'h0, ifc.data}, 8'hxx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(e.lo ? "nibble_lo" : "nibble_hi", {4'h0, ifc.data}, {4'h0, e.d});
        if (e.lo) chk("nibble_gap", {6'h0, e_h2, e_h1}, 8'h02);
      end
    end
    e_h2 = e_h1;
    e_h1 = ifc.E;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; idle(H / 2);
    scl_m = 1'b1; idle(H / 2);
    sda_m = 1'b0; idle(H / 2);
    scl_m = 1'b0; idle(H / 2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; idle(H / 2);
    scl_m = 1'b1; idle(H / 2);
    sda_m = 1'b1; idle(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    idle(H / 2);
    scl_m = 1'b1; idle(H);
    scl_m = 1'b0; idle(H / 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack, input logic nib);
    if (nib) begin
      q.push_back('{d: b[7:4], lo: 1'b0});
      q.push_back('{d: b[3:0], lo: 1'b1});
    end
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; idle(H / 2);
    scl_m = 1'b1; idle(H / 2);
    chk("ack", {7'h0, ifc.sda_oe}, {7'h0, ack});
    idle(H / 2);
    scl_m = 1'b0; idle(H / 2);
  endtask

  initial begin
    idle(5);
    chk("rst_sda_oe", {7'h0, ifc.sda_oe}, 8'h00);
    chk("rst_E",      {7'h0, ifc.E},      8'h00);
    chk("rst_data",   {4'h0, ifc.data},   8'h00);
    chk("rst_busy",   {7'h0, ifc.busy},   8'h00);
    reset = 1'b0;
    idle(10);

    // Basic write: address 0x42, bytes A5 and 3C.
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0);
    chk("busy_after_match", {7'h0, ifc.busy}, 8'h01);
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    i2c_stop();
    chk("busy_after_stop", {7'h0, ifc.busy}, 8'h00);

    // Wrong address, then a good transaction.
    i2c_start();
    send_byte(8'h86, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    chk("busy_wrong_addr", {7'h0, ifc.busy}, 8'h00);
    i2c_stop();
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0);
    send_byte(8'h69, 1'b1, 1'b1);
    i2c_stop();

    // Read request is NACKed and ignored until STOP.
    i2c_start();
    send_byte(8'h85, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    chk("busy_read", {7'h0, ifc.busy}, 8'h00);
    i2c_stop();

    // 33 bytes: the last one exceeds the per-transaction limit.
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0);
    for (int i = 0; i < 33; i++) send_byte(8'(i), i < 32, i < 32);
    chk("busy_overflow", {7'h0, ifc.busy}, 8'h00);
    i2c_stop();

    // Repeated START restarts the byte count.
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'hBB, 1'b1, 1'b1);
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b1);
    i2c_stop();

    // Reset while the address ACK is driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i));
    sda_m = 1'b1; idle(H / 2);
    scl_m = 1'b1; idle(H / 2);
    chk("ack_before_reset", {7'h0, ifc.sda_oe}, 8'h01);
    reset = 1'b1;
    idle(1);
    chk("oe_after_reset",   {7'h0, ifc.sda_oe}, 8'h00);
    chk("busy_after_reset", {7'h0, ifc.busy},   8'h00);
    reset = 1'b0;
    idle(H / 2);
    scl_m = 1'b0; idle(H / 2);
    send_byte(8'hF0, 1'b0, 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b1);
    i2c_stop();

`ifdef I2C_GLITCH_FILTER_EN
    // A 1-clk SDA dip while SCL is high must not register as START.
    sda_m = 1'b0; idle(1);
    sda_m = 1'b1; idle(H);
    scl_m = 1'b0; idle(H / 2);
    send_byte(8'h84, 1'b0, 1'b0);
    chk("glitch_busy", {7'h0, ifc.busy}, 8'h00);
    i2c_stop();
`endif

    idle(50);
    chk("queue_empty", 8'(q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
